// File: rtl/chip8_mem_arbiter_pkg.sv
// chip8_mem_arbiter_pkg: shared defaults, FSM encoding and requester IDs for the CHIP-8 RAM arbiter
package chip8_mem_arbiter_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, SINGLE = 2'd1, VID_BURST = 2'd2} arb_state_e;
   typedef enum logic [1:0] {NONE = 2'd0, LD = 2'd1, CPU = 2'd2, VID = 2'd3} req_id_e;
endpackage

// File: rtl/chip8_mem_arbiter_starve_ctr.sv
// chip8_starve_ctr: saturating CPU wait counter, flags starvation once it reaches STARVE_MAX
module chip8_starve_ctr #(
   parameter int STARVE_MAX = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_req_i,
   input  logic cpu_gnt_i,
   output logic starved_o
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] wait_q, wait_d;
   // count cycles the CPU waits, hold at the limit, clear once it is served
   always_comb wait_d = cpu_gnt_i ? '0 : (cpu_req_i && !starved_o) ? wait_q + CW'(1) : wait_q;
   assign starved_o = (wait_q == CW'(STARVE_MAX));
   // wait counter register
   always_ff @(posedge clk or posedge reset)
      if (reset) wait_q <= '0;
      else wait_q <= wait_d;
endmodule

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: single-port RAM arbiter for loader, CPU and video; CHIP8_ARB_RR_EN enables CPU/video round-robin
module chip8_mem_arbiter
   import chip8_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int BURST_MAX  = 8,
   parameter int STARVE_MAX = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              vid_req,
   input  logic              vid_burst,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int BW = $clog2(BURST_MAX + 1);
   arb_state_e state_q, state_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic cpu_rvalid_q, vid_rvalid_q;
   req_id_e win;
   logic starved, cpu_starved, exhausted, keep_burst, cpu_first;
   chip8_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk       (clk),
      .reset     (reset),
      .cpu_req_i (cpu_req),
      .cpu_gnt_i (cpu_gnt),
      .starved_o (starved)
   );
`ifdef CHIP8_ARB_RR_EN
   logic rr_cpu_q;
   // last-winner pointer: CPU goes first after video won, and out of reset
   always_ff @(posedge clk or posedge reset)
      if (reset) rr_cpu_q <= 1'b1;
      else if (cpu_gnt || vid_gnt) rr_cpu_q <= vid_gnt;
   assign cpu_first = rr_cpu_q && cpu_req && vid_req && !vid_burst;
`else
   assign cpu_first = 1'b0;
`endif
   assign cpu_starved = starved && cpu_req;
   // arbitrate and pick the next state; a completed row burst leaves one cycle open to loader and starved CPU only
   always_comb begin
      win = NONE;
      state_d = IDLE;
      bcnt_d = '0;
      exhausted = (state_q == VID_BURST) && (bcnt_q == BW'(BURST_MAX));
      keep_burst = (state_q == VID_BURST) && vid_req && !exhausted && !ld_req && !cpu_starved;
      if (reset) win = NONE;
      else if (ld_req) win = LD;
      else if (cpu_starved) win = CPU;
      else if (keep_burst) win = VID;
      else if (exhausted) win = NONE;
      else if (cpu_first) win = CPU;
      else if (vid_req) win = VID;
      else if (cpu_req) win = CPU;
      if (win == VID) begin
         state_d = (keep_burst || vid_burst) ? VID_BURST : SINGLE;
         bcnt_d = keep_burst ? bcnt_q + BW'(1) : vid_burst ? BW'(1) : '0;
      end else if (win != NONE) state_d = SINGLE;
   end
   assign ld_gnt = (win == LD);
   assign cpu_gnt = (win == CPU);
   assign vid_gnt = (win == VID);
   assign mem_en = (win != NONE);
   assign mem_we = ld_gnt || (cpu_gnt && cpu_we);
   assign mem_addr = ld_gnt ? ld_addr : cpu_gnt ? cpu_addr : vid_gnt ? vid_addr : '0;
   assign mem_wdata = ld_gnt ? ld_wdata : cpu_gnt ? cpu_wdata : '0;
   assign cpu_rvalid = cpu_rvalid_q;
   assign vid_rvalid = vid_rvalid_q;
   assign rdata = (cpu_rvalid_q || vid_rvalid_q) ? mem_rdata : '0;
   // FSM, burst count and read-valid pipeline
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         bcnt_q <= '0;
         cpu_rvalid_q <= 1'b0;
         vid_rvalid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q <= bcnt_d;
         cpu_rvalid_q <= cpu_gnt && !cpu_we;
         vid_rvalid_q <= vid_gnt;
      end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: randomized scoreboard bench with a behavioural arbitration model
module tb_chip8_mem_arbiter;
   localparam int BURST = 8;
   localparam int STARVE = 16;
`ifdef CHIP8_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ld_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0, vid_burst = 1'b0;
   logic [11:0] ld_addr = '0, cpu_addr = '0, vid_addr = '0;
   logic [7:0] ld_wdata = '0, cpu_wdata = '0;
   logic ld_gnt, cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid, mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata, rdata;

   always #5 clk = ~clk;

   chip8_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .vid_req(vid_req), .vid_burst(vid_burst), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rvalid(vid_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .rdata(rdata)
   );

   function automatic logic [7:0] seed_val(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction

   // synchronous RAM attached to the DUT memory port
   bit wr_ok [4096];
   logic [7:0] ram [4096];
   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_ok[mem_addr] <= 1'b1;
         end else mem_rdata <= wr_ok[mem_addr] ? ram[mem_addr] : seed_val(mem_addr);
      end

   // reference model state
   logic [7:0] ref_mem [int];
   int cpu_wait = 0, row_len = 0, cyc = 0, mwin = 0;
   bit last_cpu = 1'b0;
   typedef struct { int cyc; bit rst; logic [24:0] v; } gexp_t;
   typedef struct { int due; bit cpu; logic [7:0] d; } rexp_t;
   gexp_t gq [$];
   rexp_t rq [$];
   int n_vec = 0, n_bad = 0;

   function automatic logic [7:0] ref_rd(input logic [11:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed_val(a);
   endfunction

   // decide this cycle's winner from the rules, queue expectations, then advance one clock
   task automatic tick();
      int w;
      bit we;
      logic [11:0] a;
      logic [7:0] d;
      w = 0;
      if (reset) w = 0;
      else if (ld_req) w = 1;
      else if (cpu_req && cpu_wait >= STARVE) w = 2;
      else if (vid_req && row_len > 0 && row_len < BURST) w = 3;
      else if (row_len == BURST) w = 0;
      else if (RR && !last_cpu && cpu_req && vid_req && !vid_burst) w = 2;
      else if (vid_req) w = 3;
      else if (cpu_req) w = 2;
      a = (w == 1) ? ld_addr : (w == 2) ? cpu_addr : (w == 3) ? vid_addr : 12'h0;
      we = (w == 1) || (w == 2 && cpu_we);
      d = (w == 1) ? ld_wdata : (w == 2 && cpu_we) ? cpu_wdata : 8'h0;
      if (reset) rq.delete();
      gq.push_back('{cyc, reset, {w == 1, w == 2, w == 3, w != 0, we, a, d}});
      if (w != 0 && !we) rq.push_back('{cyc + 1, w == 2, ref_rd(a)});
      if (we) ref_mem[int'(a)] = d;
      if (reset) begin
         cpu_wait = 0;
         row_len = 0;
         last_cpu = 1'b0;
      end else begin
         row_len = (w != 3) ? 0 : (row_len > 0 && row_len < BURST) ? row_len + 1 : (vid_burst ? 1 : 0);
         cpu_wait = (w == 2) ? 0 : (cpu_req && cpu_wait < STARVE) ? cpu_wait + 1 : cpu_wait;
         if (w == 2) last_cpu = 1'b1;
         if (w == 3) last_cpu = 1'b0;
      end
      mwin = w;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int c, input logic [24:0] act, input logic [24:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
      end
   endtask

   // monitor: compare DUT outputs against queued expectations, away from the clock edge
   initial begin
      gexp_t g;
      logic [24:0] m;
      logic [1:0] rv;
      forever begin
         @(negedge clk);
         if (gq.size() > 0) begin
            g = gq.pop_front();
            m = {5'h1f, {12{g.v[21] | g.rst}}, {8{g.v[20] | g.rst}}};
            chk("grant", g.cyc, {ld_gnt, cpu_gnt, vid_gnt, mem_en, mem_we, mem_addr, mem_wdata} & m, g.v & m);
            rv = (rq.size() > 0 && rq[0].due == g.cyc) ? (rq[0].cpu ? 2'b10 : 2'b01) : 2'b00;
            chk("rvalid", g.cyc, {23'h0, cpu_rvalid, vid_rvalid}, {23'h0, rv});
            if (rv != 2'b00) begin
               chk("rdata", g.cyc, {17'h0, rdata}, {17'h0, rq[0].d});
               void'(rq.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic idle_all();
      ld_req = 1'b0;
      cpu_req = 1'b0;
      vid_req = 1'b0;
      vid_burst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      // loader writes 0xA2 to 0x200, CPU reads it back
      ld_req = 1'b1; ld_addr = 12'h200; ld_wdata = 8'hA2;
      tick();
      idle_all();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
      tick();
      idle_all();
      repeat (2) tick();
      // 12-cycle video burst with the CPU idle
      vid_req = 1'b1; vid_burst = 1'b1; vid_addr = 12'h300;
      repeat (12) tick();
      idle_all();
      repeat (2) tick();
      // continuous video burst while the CPU waits for service
      vid_req = 1'b1; vid_burst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h2F0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mwin == 2) cpu_req = 1'b0;
      end
      idle_all();
      repeat (2) tick();
      // loader preempts a running burst
      vid_req = 1'b1; vid_burst = 1'b1;
      repeat (3) tick();
      ld_req = 1'b1; ld_addr = 12'h050; ld_wdata = 8'hF0;
      tick();
      ld_req = 1'b0;
      repeat (3) tick();
      idle_all();
      tick();
      // CPU and video single requests contending
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h050;
      vid_req = 1'b1; vid_burst = 1'b0; vid_addr = 12'h400;
      repeat (20) tick();
      idle_all();
      repeat (2) tick();
      // reset pulse in the cycle after a CPU read grant
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
      tick();
      cpu_req = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      // randomized traffic honouring the hold-until-granted protocol
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
         tick();
         if (!ld_req || mwin == 1) begin
            ld_req = ($urandom_range(0, 15) == 0) || (ld_req && $urandom_range(0, 1) == 1);
            ld_addr = 12'($urandom);
            ld_wdata = 8'($urandom);
         end
         if (!cpu_req || mwin == 2) begin
            cpu_req = ($urandom_range(0, 2) == 0);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 12'($urandom);
            cpu_wdata = 8'($urandom);
         end
         if (vid_req && mwin == 3) begin
            vid_addr = vid_addr + 12'h1;
            vid_req = ($urandom_range(0, 11) != 0);
         end else if (!vid_req) begin
            vid_req = ($urandom_range(0, 3) == 0);
            vid_burst = 1'($urandom_range(0, 1));
            vid_addr = 12'($urandom);
         end
      end
      idle_all();
      repeat (3) tick();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
